pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer and synchronous flush. It replaces the fixed-field stage latches between IF/ID, ID/EX, EX/MEM and MEM/WB. Each stage packs its fields into one payload vector. Stalls propagate backward through a registered `in_ready` without combinational paths, and flushes turn the stage into a bubble.

## Interface
Parameters:
- DATA_W, 160, payload width in bits (whole packed stage record).
- CTRL_W, 16, number of low payload bits that carry side-effecting control (regs_write, mem_write, br, csr_op, ...); forced to 0 whenever the stage holds no valid entry; 0 ≤ CTRL_W ≤ DATA_W.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid record.
- in_data  in  DATA_W  upstream record.
- in_ready  out  1  stage can accept; registered.
- out_valid  out  1  stage presents a valid record.
- out_data  out  DATA_W  presented record.
- out_ready  in  1  downstream accepts this cycle.
- flush  in  1  synchronous kill of all held and incoming entries.
- occupancy  out  2  entries held (0, 1 or 2).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Storage: main entry (drives out_data) and skid entry. A state register holds one of three states:
  - EMPTY: no entries.
  - ONE: main valid.
  - FULL: main and skid valid.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Transitions (flush=0):
  - EMPTY: in_fire → ONE, main←in_data.
  - ONE: in_fire & out_fire → ONE, main←in_data. in_fire & !out_fire → FULL, skid←in_data. !in_fire & out_fire → EMPTY. Otherwise hold.
  - FULL: out_fire → ONE, main←skid. Otherwise hold. No input is accepted because in_ready=0.
- flush=1: next state EMPTY regardless of in_valid, out_ready or current state. Input in the same cycle is discarded even if in_ready=1. Main and skid payloads are zeroed.
- out_valid = (state≠EMPTY). in_ready = (state≠FULL), decoded from the registered state only.
- out_data = main. Bits [CTRL_W-1:0] read 0 whenever out_valid=0, so downstream hazard and forwarding logic sees a NOP (rd=0, no writes).
- occupancy: EMPTY=0, ONE=1, FULL=2.
- stall_cnt: increments when out_valid & !out_ready. It saturates at all-ones. stall_cnt_clr has priority over increment. flush does not clear it.
- Reset: state EMPTY; main and skid 0. Resulting values: out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.

## Timing
- Latency: a record accepted at edge N is visible on out_data after edge N (one cycle).
- Throughput: one record per cycle while out_ready=1. There are no bubbles in steady state.
- in_ready depends only on the state register. There is no combinational path from out_ready or in_valid to in_ready.
- out_valid and out_data depend only on registers.
- out_data and out_valid are stable while out_valid=1 and out_ready=0. Upstream must hold in_valid and in_data until in_fire.
- Backpressure: the first out_ready=0 cycle with a concurrent in_fire moves the stage to FULL. in_ready drops in the following cycle. No data is lost.
- Flush takes effect at the next edge: out_valid=0 and in_ready=1 in the cycle after flush.
- Reset mid-operation: asynchronous. All entries are dropped immediately. stall_cnt returns to 0.

## Structure
- Shared package `riscv_pipe_pkg`:
  - State enum (EMPTY/ONE/FULL).
  - Packed stage-record widths and CTRL_W constants per stage (e.g. ID_EX_W, ID_EX_CTRL_W).
  - Field offsets used to pack and unpack records.
- One sub-module: `pipe_sat_cnt`, a saturating counter with clear and enable (width parameter). It is also reused for other performance counters.

## Test plan
- Reset, then stream 8 records 0x1..0x8 with out_ready=1 → outputs 0x1..0x8 on 8 consecutive cycles, one cycle after acceptance; occupancy stays 1 and in_ready stays 1.
- Accept 0xA, then 0xB with out_ready=0 → occupancy=2 and in_ready=0. Release out_ready → 0xA, then 0xB delivered in order; stall_cnt = number of stalled cycles.
- FULL state with flush=1 and in_valid=1 (data 0xC) → next cycle out_valid=0, occupancy=0, in_ready=1, out_data[CTRL_W-1:0]=0; 0xC is never delivered.
- Hold out_ready=0 for 2^CNT_W+5 cycles with a valid entry → stall_cnt saturates at all-ones. Assert stall_cnt_clr → 0 next cycle.
- Deassert rstn asynchronously mid-stream while in FULL → out_valid=0, out_data=0 and in_ready=1 immediately; after release, the first new record appears one cycle after acceptance.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared definitions for the pipeline-stage registers of the core.
//   - pipe_state_e / ST_* : occupancy state of a pipe_stage_buf
//   - *_W / *_CTRL_W      : packed record width and control-field width
//                           for each stage boundary (IF/ID, ID/EX, EX/MEM,
//                           MEM/WB)
//   - *_OFF               : bit offsets used to pack and unpack records
//   - occupancy_of()      : maps a state to the number of held entries
// Every record keeps its side-effecting control bits (including rd) in the
// lowest bits, so a stage buffer can blank them to make a bubble look
// like a NOP to hazard and forwarding logic.
// ---------------------------------------------------------------------------
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    // Plain constants for code that keeps its state in a logic vector.
    localparam logic [1:0] ST_EMPTY = PIPE_EMPTY;
    localparam logic [1:0] ST_ONE   = PIPE_ONE;
    localparam logic [1:0] ST_FULL  = PIPE_FULL;

    // ---------------- IF/ID record ----------------
    localparam int IF_ID_CTRL_W    = 1;
    localparam int IF_ID_PRED_OFF  = 0;
    localparam int IF_ID_PC_OFF    = 1;
    localparam int IF_ID_INSTR_OFF = 33;
    localparam int IF_ID_W         = 65;

    // ---------------- ID/EX record ----------------
    // Control field: reg_write, mem_read, mem_write, branch, jump,
    // csr_op[1:0], rd[4:0], four reserved bits.
    localparam int ID_EX_CTRL_W      = 16;
    localparam int ID_EX_REGW_OFF    = 0;
    localparam int ID_EX_MEMR_OFF    = 1;
    localparam int ID_EX_MEMW_OFF    = 2;
    localparam int ID_EX_BR_OFF      = 3;
    localparam int ID_EX_JMP_OFF     = 4;
    localparam int ID_EX_CSR_OFF     = 5;
    localparam int ID_EX_RD_OFF      = 7;
    localparam int ID_EX_ALUOP_OFF   = 16;
    localparam int ID_EX_RS1_OFF     = 20;
    localparam int ID_EX_RS2_OFF     = 25;
    localparam int ID_EX_PC_OFF      = 30;
    localparam int ID_EX_RS1VAL_OFF  = 62;
    localparam int ID_EX_RS2VAL_OFF  = 94;
    localparam int ID_EX_IMM_OFF     = 126;
    localparam int ID_EX_W           = 158;

    // ---------------- EX/MEM record ----------------
    // Control field: reg_write, mem_read, mem_write, rd[4:0].
    localparam int EX_MEM_CTRL_W     = 8;
    localparam int EX_MEM_REGW_OFF   = 0;
    localparam int EX_MEM_MEMR_OFF   = 1;
    localparam int EX_MEM_MEMW_OFF   = 2;
    localparam int EX_MEM_RD_OFF     = 3;
    localparam int EX_MEM_ALU_OFF    = 8;
    localparam int EX_MEM_STDATA_OFF = 40;
    localparam int EX_MEM_FUNCT3_OFF = 72;
    localparam int EX_MEM_W          = 75;

    // ---------------- MEM/WB record ----------------
    // Control field: reg_write, rd[4:0], two reserved bits.
    localparam int MEM_WB_CTRL_W     = 8;
    localparam int MEM_WB_REGW_OFF   = 0;
    localparam int MEM_WB_RD_OFF     = 1;
    localparam int MEM_WB_WBDATA_OFF = 8;
    localparam int MEM_WB_W          = 40;

    // Entries held in each state; the encoding is chosen so this is the
    // state value itself, but callers should not rely on that.
    function automatic logic [1:0] occupancy_of(input logic [1:0] st);
        case (st)
            ST_ONE:  occupancy_of = 2'd1;
            ST_FULL: occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// ---------------------------------------------------------------------------
// pipe_sat_cnt
// Saturating up-counter with synchronous clear, used for stall and other
// performance counters.
// Ports:
//   clk   in  clock
//   rstn  in  asynchronous active-low reset (count -> 0)
//   clr   in  synchronous clear, wins over en
//   en    in  count this cycle
//   count out current value, sticks at all-ones
// ---------------------------------------------------------------------------
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear first, then increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
// Pipeline-stage register with valid/ready handshake and a one-entry skid
// buffer. in_ready comes straight from the state register, so backpressure
// never forms a combinational path across stages; the skid entry catches
// the one record that can arrive in the cycle downstream first stalls.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   in_valid/in_data   upstream record, held until accepted
//   in_ready           stage can accept (registered)
//   out_valid/out_data presented record; low CTRL_W bits are 0 when invalid
//   out_ready          downstream accepts this cycle
//   flush              synchronous kill of held and incoming records
//   occupancy          entries held (0..2)
//   stall_cnt          saturating count of out_valid & !out_ready cycles
//   stall_cnt_clr      synchronous clear of stall_cnt
// ---------------------------------------------------------------------------
module pipe_stage_buf
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    // Ones in the control field; a shift by the full width yields zero,
    // which covers CTRL_W == DATA_W, and CTRL_W == 0 gives an empty mask.
    localparam logic [DATA_W-1:0] CTRL_MASK = ~({DATA_W{1'b1}} << CTRL_W);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    logic in_fire;
    logic out_fire;
    logic stalled;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stalled   = out_valid & ~out_ready;

    // Next-state and payload movement. Flush overrides everything and also
    // zeroes the payloads so no stale record can leak out later. Draining
    // to EMPTY leaves main in place; the control mask on out_data already
    // makes it look like a NOP.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Blank control bits while invalid so downstream sees rd=0, no writes.
    assign out_data  = out_valid ? main_q : (main_q & ~CTRL_MASK);
    assign occupancy = occupancy_of(state_q);

    pipe_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (stall_cnt_clr),
        .en    (stalled),
        .count (stall_cnt)
    );

endmodule
